sobel_window_engine: RTL and testbench
======================================

Name: sobel_window_engine

Overview:
- Raster-scan engine sitting directly downstream of image_mem; drives its row/col address and consumes its combinational pixel output.
- For every interior pixel, fetches the 3x3 neighbourhood, one read per cycle, and accumulates Sobel Gx and Gy.
- Emits the saturated gradient magnitude |Gx|+|Gy| with its coordinates over a valid/ready stream to the edge-map writer.

Parameters:
- IMG_WIDTH, 8, image columns (>=3)
- IMG_HEIGHT, 8, image rows (>=3)
- DATA_WIDTH, 8, pixel and magnitude width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin frame scan; sampled only in IDLE
- row  out  $clog2(IMG_HEIGHT)  read row address to image_mem
- col  out  $clog2(IMG_WIDTH)  read column address to image_mem
- pixel  in  DATA_WIDTH  image_mem data, valid in the same cycle as row/col
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_row  out  $clog2(IMG_HEIGHT)  centre row of result
- out_col  out  $clog2(IMG_WIDTH)  centre column of result
- out_mag  out  DATA_WIDTH  gradient magnitude
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values: state IDLE, row/col/out_row/out_col/out_mag 0, out_valid/busy/done 0, accumulators 0. Reset mid-frame aborts the frame immediately. No done pulse is produced for the aborted frame.
- FSM states: IDLE, FETCH, CALC, OUT, DONE.
- IDLE:
  - On start=1, load centre (r,c)=(1,1), clear k and accumulators, set busy, go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - Kernel index k runs 0..8, with dr=k/3 and dc=k%3.
  - row=r+dr-1, col=c+dc-1, driven from registers.
  - pixel is sampled the same cycle: Gx += wx[k]*pixel, Gy += wy[k]*pixel.
  - wx = -1,0,1,-2,0,2,-1,0,1. wy = -1,-2,-1,0,0,0,1,2,1.
  - After k=8 (9 cycles), go to CALC.
- CALC (1 cycle):
  - mag = |Gx|+|Gy|, saturated to 2^DATA_WIDTH-1.
  - Register out_mag, out_row=r, out_col=c. Go to OUT.
- OUT:
  - out_valid=1. out_mag/out_row/out_col stay stable until the handshake (out_valid&&out_ready).
  - On handshake, clear out_valid and advance c. If c==IMG_WIDTH-2, set c=1 and r+=1.
  - If the accepted pixel was (IMG_HEIGHT-2, IMG_WIDTH-2), go to DONE. Otherwise clear k and accumulators and go to FETCH.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Row/col outside FETCH hold their last value.
- Arithmetic:
  - Accumulators are signed, DATA_WIDTH+4 bits (|G| max 4*(2^DATA_WIDTH-1)).
  - Magnitude sum uses DATA_WIDTH+4 unsigned bits before saturation.
- Border pixels (row/col 0 or max) produce no output. A frame emits exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) results.
- Latency:
  - First out_valid appears 11 cycles after the start-sampling edge.
  - With out_ready held high, each result takes 11 cycles.
  - busy rises on the cycle after start is sampled.

Optional Feature:
- SOBEL_THRESHOLD_EN: adds parameter THRESH (default 64).
- In CALC, out_mag = (mag > THRESH) ? 2^DATA_WIDTH-1 : 0, giving a binary edge map.
- Without the macro, out_mag is the saturated magnitude. Port list is identical either way.

Decomposition:
- Package sobel_pkg holds:
  - state enum (IDLE, FETCH, CALC, OUT, DONE)
  - kernel weight constants wx/wy as 9-entry signed 3-bit arrays
  - ACC_W = DATA_WIDTH+4 helper function
- Sub-module sobel_mag_sat: combinational abs/abs/add/saturate (plus threshold under the macro), instantiated in CALC.

Test Plan:
- 8x8 pattern p[i][j]=i*j, out_ready=1 -> 36 results, raster order. (1,1): mag 16. (3,5): mag 64. (6,6): mag 96; in general mag=8r+8c. done pulses once, 1 cycle after the last handshake.
- Step-edge model (pixel=255 for col>=2, else 0), 8x8 -> (r,1) and (r,2): Gx=1020, saturates to out_mag=255. Columns >=3: out_mag=0.
- Backpressure: out_ready low for 5 cycles during the first OUT -> out_valid held, out_mag=16 stable, no address change. Scan resumes after the handshake.
- 3x3 image (IMG_WIDTH=IMG_HEIGHT=3) -> exactly one result at (1,1), then done. Start pulsed while busy is ignored.
- rst_n low during FETCH of the 4th pixel -> next cycle all outputs 0, state IDLE, no done. A new start rescans from (1,1).
- With SOBEL_THRESHOLD_EN, THRESH=64, i*j pattern -> out_mag=255 where 8r+8c>64, else 0. (4,4) gives 0. (4,5) gives 255.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window engine: FSM state
// encoding, the 3x3 Sobel kernel weights and the accumulator width helper.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CALC,
    OUT,
    DONE
  } state_e;

  localparam int KERNEL_TAPS = 9;

  // Kernel taps in raster order k = 3*dr + dc over the 3x3 window.
  localparam logic signed [2:0] WX [KERNEL_TAPS] = '{
    -3'sd1, 3'sd0, 3'sd1,
    -3'sd2, 3'sd0, 3'sd2,
    -3'sd1, 3'sd0, 3'sd1
  };

  localparam logic signed [2:0] WY [KERNEL_TAPS] = '{
    -3'sd1, -3'sd2, -3'sd1,
     3'sd0,  3'sd0,  3'sd0,
     3'sd1,  3'sd2,  3'sd1
  };

  // |G| can reach 4*(2^DATA_WIDTH-1); four extra bits hold that plus sign.
  function automatic int acc_w(input int data_width);
    return data_width + 4;
  endfunction

endpackage

// File: rtl/sobel_mag_sat.sv
// Combinational |Gx|+|Gy| with saturation to the pixel range.
// Build option SOBEL_THRESHOLD_EN: turns the magnitude into a binary edge
// decision against parameter THRESH (all-ones above THRESH, zero otherwise).
module sobel_mag_sat #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 12
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int THRESH     = 64
`endif
) (
  input  logic signed [ACC_W-1:0]      i_gx,
  input  logic signed [ACC_W-1:0]      i_gy,
  output logic        [DATA_WIDTH-1:0] o_mag
);

  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

  logic [ACC_W-1:0]      w_abs_gx;
  logic [ACC_W-1:0]      w_abs_gy;
  logic [ACC_W-1:0]      w_sum;
  logic [DATA_WIDTH-1:0] w_sat;

  assign w_abs_gx = i_gx[ACC_W-1] ? -i_gx : i_gx;
  assign w_abs_gy = i_gy[ACC_W-1] ? -i_gy : i_gy;
  assign w_sum    = w_abs_gx + w_abs_gy;
  assign w_sat    = (w_sum > MAG_MAX) ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];

`ifdef SOBEL_THRESHOLD_EN
  localparam logic [ACC_W-1:0] THR = ACC_W'(THRESH);
  assign o_mag = (ACC_W'(w_sat) > THR) ? {DATA_WIDTH{1'b1}} : '0;
`else
  assign o_mag = w_sat;
`endif

endmodule

// File: rtl/sobel_window_engine.sv
// Raster-scan Sobel engine. Walks every interior pixel of an image held in
// image_mem, reads its 3x3 neighbourhood one pixel per cycle, accumulates
// Gx/Gy and streams the saturated magnitude with its coordinates.
// Build option SOBEL_THRESHOLD_EN: adds parameter THRESH and emits a binary
// edge map instead of the magnitude; the port list does not change.
module sobel_window_engine
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_WIDTH = 8
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int THRESH     = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  input  logic [DATA_WIDTH-1:0]         pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic [DATA_WIDTH-1:0]         out_mag,
  output logic                          busy,
  output logic                          done
);

  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int ACC_W = acc_w(DATA_WIDTH);

  localparam logic [3:0]    K_LAST   = 4'd8;
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 2);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 2);

  state_e r_state;
  state_e w_next_state;

  logic [RW-1:0]         r_r;        // centre row of the current window
  logic [CW-1:0]         r_c;        // centre column of the current window
  logic [RW-1:0]         r_row;      // read address presented to image_mem
  logic [CW-1:0]         r_col;
  logic [3:0]            r_k;        // kernel tap index 0..8
  logic signed [ACC_W-1:0] r_gx;
  logic signed [ACC_W-1:0] r_gy;
  logic [RW-1:0]         r_out_row;
  logic [CW-1:0]         r_out_col;
  logic [DATA_WIDTH-1:0] r_out_mag;

  logic                    w_busy;
  logic                    w_done;
  logic                    w_out_valid;
  logic                    w_handshake;
  logic                    w_last;
  logic                    w_wrap;
  logic [RW-1:0]           w_next_r;
  logic [CW-1:0]           w_next_c;
  logic signed [ACC_W-1:0] w_px;
  logic signed [ACC_W-1:0] w_gx_term;
  logic signed [ACC_W-1:0] w_gy_term;
  logic [DATA_WIDTH-1:0]   w_mag;

  // Pixel is unsigned; zero-extend into the signed accumulator domain.
  assign w_px      = ACC_W'({4'b0000, pixel});
  assign w_gx_term = ACC_W'(WX[r_k]) * w_px;
  assign w_gy_term = ACC_W'(WY[r_k]) * w_px;

  assign w_handshake = w_out_valid && out_ready;
  assign w_last      = (r_r == LAST_ROW) && (r_c == LAST_COL);
  assign w_wrap      = (r_c == LAST_COL);
  assign w_next_r    = w_wrap ? r_r + 1'b1 : r_r;
  assign w_next_c    = w_wrap ? CW'(1) : r_c + 1'b1;

  sobel_mag_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
`ifdef SOBEL_THRESHOLD_EN
    ,
    .THRESH     (THRESH)
`endif
  ) u_mag_sat (
    .i_gx  (r_gx),
    .i_gy  (r_gy),
    .o_mag (w_mag)
  );

  // State register; synchronous reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next_state = FETCH;
      end
      FETCH: if (r_k == K_LAST) w_next_state = CALC;
      CALC:  w_next_state = OUT;
      OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next_state = w_last ? DONE : FETCH;
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: window position, read address, accumulators and result regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r       <= '0;
      r_c       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_k       <= '0;
      r_gx      <= '0;
      r_gy      <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_out_mag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_r   <= RW'(1);
            r_c   <= CW'(1);
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_gx  <= '0;
            r_gy  <= '0;
          end
        end
        FETCH: begin
          r_gx <= r_gx + w_gx_term;
          r_gy <= r_gy + w_gy_term;
          // Step the address to the next tap; after the last tap it holds.
          if (r_k != K_LAST) begin
            r_k <= r_k + 1'b1;
            if (r_col == r_c + 1'b1) begin
              r_col <= r_c - 1'b1;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        CALC: begin
          r_out_mag <= w_mag;
          r_out_row <= r_r;
          r_out_col <= r_c;
        end
        OUT: begin
          if (w_handshake && !w_last) begin
            r_r   <= w_next_r;
            r_c   <= w_next_c;
            r_row <= w_next_r - 1'b1;
            r_col <= w_next_c - 1'b1;
            r_k   <= '0;
            r_gx  <= '0;
            r_gy  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign row       = r_row;
  assign col       = r_col;
  assign out_valid = w_out_valid;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign out_mag   = r_out_mag;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule

// File: tb/tb_sobel_window_engine.sv
// Directed bench for sobel_window_engine: an 8x8 instance fed by a
// combinational image model (i*j or step edge) and a 3x3 instance.
module tb_sobel_window_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, out_ready;
  logic [2:0] row, col, out_row, out_col;
  logic [7:0] pixel, out_mag;
  logic       out_valid, busy, done;

  logic       start3, out_ready3;
  logic [1:0] row3, col3, out_row3, out_col3;
  logic [7:0] pixel3, out_mag3;
  logic       out_valid3, busy3, done3;

  int pat = 0;  // 0: p[i][j]=i*j, 1: 255 for col>=2 else 0
  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    if (pat == 1) pixel = (col >= 3'd2) ? 8'd255 : 8'd0;
    else          pixel = 8'(int'(row) * int'(col));
  end

  always_comb pixel3 = 8'(int'(row3) * int'(col3));

  sobel_window_engine #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row), .col(col),
    .pixel(pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_mag(out_mag),
    .busy(busy), .done(done)
  );

  sobel_window_engine #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .row(row3), .col(col3),
    .pixel(pixel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_row(out_row3), .out_col(out_col3), .out_mag(out_mag3),
    .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output: i*j gives Gx=8r, Gy=8c; the step edge gives Gx=1020
  // for windows touching columns 1 and 2, zero elsewhere.
  function automatic int exp_mag(input int r, input int c);
    int m;
    if (pat == 1) m = (c <= 2) ? 1020 : 0;
    else          m = 8 * r + 8 * c;
    if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
    m = (m > 64) ? 255 : 0;
`endif
    return m;
  endfunction

  // Collect the rest of an 8x8 frame with out_ready high, starting at raster
  // index first_idx; checks order, values, spacing and the done pulse.
  task automatic run8(input int first_idx);
    int idx        = first_idx;
    int last_valid = -1;
    int n_done     = 0;
    bit fin        = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      tick();
      if (done) begin
        n_done++;
        check("done_after_last_handshake", cyc, last_valid + 1);
      end else if (n_done > 0) begin
        fin = 1;
      end
      if (out_valid) begin
        if (idx < 36) begin
          check("res_row", out_row, 1 + idx / 6);
          check("res_col", out_col, 1 + idx % 6);
          check("res_mag", out_mag, exp_mag(1 + idx / 6, 1 + idx % 6));
        end
        if (last_valid >= 0) check("result_spacing", cyc - last_valid, 11);
        last_valid = cyc;
        idx++;
      end
    end
    check("result_count", idx, 36);
    check("done_pulses", n_done, 1);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    int seen;
    int n_done;
    int n_v3;
    bit found;

    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    start3     = 1'b0;
    out_ready3 = 1'b1;
    pat        = 0;

    // Reset state.
    tick();
    tick();
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_mag", out_mag, 0);
    check("rst_out_rc", {out_row, out_col}, 0);
    rst_n = 1'b1;
    tick();

    // Frame 1 (i*j): latency, then backpressure on the first result.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_addr", {row, col}, {3'd0, 3'd0});
    repeat (9) tick();
    check("valid_low_in_calc", out_valid, 0);
    tick();  // 11th cycle after the start cycle: OUT
    check("first_valid", out_valid, 1);
    check("first_mag", out_mag, exp_mag(1, 1));
    check("first_rc", {out_row, out_col}, {3'd1, 3'd1});
    check("addr_after_fetch", {row, col}, {3'd2, 3'd2});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_mag", out_mag, exp_mag(1, 1));
      check("bp_addr", {row, col}, {3'd2, 3'd2});
    end
    out_ready = 1'b1;
    tick();  // handshake edge
    check("post_hs_valid", out_valid, 0);
    check("post_hs_addr", {row, col}, {3'd0, 3'd1});
    run8(1);

    // Frame 2: step edge saturation.
    pat   = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run8(0);

    // Frame 3: reset while fetching the 4th window (1,4).
    pat   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen  = 0;
    for (int cyc = 0; cyc < 200 && seen < 3; cyc++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_seen_three", seen, 3);
    tick();  // handshake of (1,3): FETCH k=0 of (1,4)
    check("abort_fetch_addr", {row, col}, {3'd0, 3'd3});
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_row", row, 0);
    check("abort_col", col, 0);
    check("abort_out_rc", {out_row, out_col}, 0);
    check("abort_out_mag", out_mag, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("abort_no_done_or_busy", n_done, 0);

    // Frame 4: restart after abort scans from (1,1) again.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_addr", {row, col}, {3'd0, 3'd0});
    run8(0);

    // 3x3 image: one result, start while busy is ignored.
    start3 = 1'b1;
    tick();
    check("b3_busy", busy3, 1);
    for (int i = 0; i < 3; i++) tick();  // start3 still high while busy
    start3 = 1'b0;
    found  = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid3) found = 1;
      else tick();
    end
    check("b3_valid_seen", found, 1);
    check("b3_rc", {out_row3, out_col3}, {2'd1, 2'd1});
    check("b3_mag", out_mag3, exp_mag(1, 1));
    tick();
    check("b3_done", done3, 1);
    check("b3_valid_cleared", out_valid3, 0);
    tick();
    check("b3_idle", {busy3, done3}, 0);
    n_v3 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid3 || busy3) n_v3++;
    end
    check("b3_single_result", n_v3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
